// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, FSM state, flag type and operand classifier for fp_mult_issue
package fp_pkg;

  localparam int unsigned FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } fp_state_e;

  // {invalid, overflow, zero}
  typedef logic [2:0] fp_flags_t;

  localparam fp_flags_t FLG_NONE     = 3'b000;
  localparam fp_flags_t FLG_INVALID  = 3'b100;
  localparam fp_flags_t FLG_OVERFLOW = 3'b010;
  localparam fp_flags_t FLG_ZERO     = 3'b001;

  typedef struct packed {
    logic      special;
    logic [31:0] res;
    fp_flags_t flags;
  } fp_class_t;

  // Resolves every outcome that does not need the multiplier result; the
  // overflow/normal decision is left to the issue cycle.
  function automatic fp_class_t fp_classify(input logic [31:0] a, input logic [31:0] b);
    fp_class_t c;
    logic      nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic      sign;
    logic [9:0] esum;
    nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    zero_a = (a[30:23] == 8'h00);
    zero_b = (b[30:23] == 8'h00);
    sign   = a[31] ^ b[31];
    esum   = {2'b00, a[30:23]} + {2'b00, b[30:23]};
    c.special = 1'b0;
    c.res     = 32'd0;
    c.flags   = FLG_NONE;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      c.special = 1'b1;
      c.res     = FP_QNAN;
      c.flags   = FLG_INVALID;
    end else if (inf_a || inf_b) begin
      c.special = 1'b1;
      c.res     = FP_INF | {sign, 31'd0};
    end else if (zero_a || zero_b || (esum <= 10'(FP_BIAS))) begin
      c.special = 1'b1;
      c.res     = {sign, 31'd0};
      c.flags   = FLG_ZERO;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_mult_issue_if.sv
// rtl/fp_mult_issue_if.sv - operand/result handshake and fp_mult side-band bundle
interface fp_mult_issue_if;
  import fp_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_opd1;
  logic [31:0] in_opd2;
  logic [31:0] mul_opd1;
  logic [31:0] mul_opd2;
  logic [31:0] mul_res;
  logic        mul_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  fp_flags_t   out_flags;

  modport master (
    output in_valid, in_opd1, in_opd2, out_ready, mul_res, mul_overflow,
    input  in_ready, mul_opd1, mul_opd2, out_valid, out_res, out_flags
  );

  modport slave (
    input  in_valid, in_opd1, in_opd2, out_ready, mul_res, mul_overflow,
    output in_ready, mul_opd1, mul_opd2, out_valid, out_res, out_flags
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers for full/empty detection
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo DEPTH must be a power of 2 and at least 2");
  end

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/fp_mult_issue.sv
// rtl/fp_mult_issue.sv - queues operand pairs, issues them to an external fp_mult and fixes up special cases
module fp_mult_issue
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_mult_issue_if.slave  bus
);

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [63:0] fifo_rdata;

  fp_state_e   state_q, state_d;
  logic [31:0] opd1_q, opd1_d;
  logic [31:0] opd2_q, opd2_d;
  fp_class_t   cls_q, cls_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_res_q, out_res_d;
  fp_flags_t   out_flags_q, out_flags_d;
  logic        res_sign;

  assign fifo_push = bus.in_valid && !fifo_full;
  assign res_sign  = opd1_q[31] ^ opd2_q[31];

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({bus.in_opd1, bus.in_opd2}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    opd1_d      = opd1_q;
    opd2_d      = opd2_q;
    cls_d       = cls_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_flags_d = out_flags_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
        if (cls_q.special) begin
          out_res_d   = cls_q.res;
          out_flags_d = cls_q.flags;
        end else if (bus.mul_overflow) begin
          out_res_d   = FP_INF | {res_sign, 31'd0};
          out_flags_d = FLG_OVERFLOW;
        end else begin
          out_res_d   = bus.mul_res;
          out_flags_d = FLG_NONE;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Classification is captured with the operands so the issue cycle only
    // has to merge in the multiplier's overflow flag.
    if (fifo_pop) begin
      opd1_d = fifo_rdata[63:32];
      opd2_d = fifo_rdata[31:0];
      cls_d  = fp_classify(fifo_rdata[63:32], fifo_rdata[31:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opd1_q      <= '0;
      opd2_q      <= '0;
      cls_q       <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= FLG_NONE;
    end else begin
      state_q     <= state_d;
      opd1_q      <= opd1_d;
      opd2_q      <= opd2_d;
      cls_q       <= cls_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.mul_opd1  = opd1_q;
  assign bus.mul_opd2  = opd2_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_mult_issue.sv
// tb/tb_fp_mult_issue.sv - scoreboard bench for fp_mult_issue with a behavioural fp_mult
module tb_fp_mult_issue;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [34:0] exp_q [$];

  fp_mult_issue_if bus ();

  fp_mult_issue #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating single-precision multiplier standing in for the downstream fp_mult.
  function automatic logic [32:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    logic        ovf;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    ovf = !e[9] && (e >= 10'd255);
    return {ovf, a[31] ^ b[31], e[7:0], m};
  endfunction

  always_comb {bus.mul_overflow, bus.mul_res} = fmul_model(bus.mul_opd1, bus.mul_opd2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per accepted result and checks stall stability.
  initial begin
    logic        stall_prev;
    logic [31:0] held_res;
    logic [2:0]  held_flags;
    logic [34:0] e;
    stall_prev = 1'b0;
    held_res   = '0;
    held_flags = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!bus.out_valid || bus.out_res !== held_res || bus.out_flags !== held_flags) begin
            errors++;
            $display("FAIL hold_stable: got valid=%b res=%h flags=%b expected valid=1 res=%h flags=%b",
                     bus.out_valid, bus.out_res, bus.out_flags, held_res, held_flags);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got res=%h flags=%b expected no output",
                     bus.out_res, bus.out_flags);
          end else begin
            e = exp_q.pop_front();
            if (bus.out_res !== e[34:3] || bus.out_flags !== e[2:0]) begin
              errors++;
              $display("FAIL result: got res=%h flags=%b expected res=%h flags=%b",
                       bus.out_res, bus.out_flags, e[34:3], e[2:0]);
            end
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held_res   = bus.out_res;
        held_flags = bus.out_flags;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [2:0] flags);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_opd1  = a;
    bus.in_opd2  = b;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) exp_q.push_back({res, flags});
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs [13] = '{
    '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100},
    '{32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b100},
    '{32'hFF800001, 32'h7F800000, 32'h7FC00000, 3'b100},
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000},
    '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010},
    '{32'h80800000, 32'h00800000, 32'h80000000, 3'b001},
    '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b001},
    '{32'h00000001, 32'h40000000, 32'h00000000, 3'b001},
    '{32'h3F000000, 32'h00800000, 32'h00000000, 3'b001},
    '{32'h3F800000, 32'h00800000, 32'h00800000, 3'b000},
    '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000},
    '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000}
  };

  vec_t bp [4] = '{
    '{32'h3F800000, 32'h40000000, 32'h40000000, 3'b000},
    '{32'h40000000, 32'h40000000, 32'h40800000, 3'b000},
    '{32'h40400000, 32'h40000000, 32'h40C00000, 3'b000},
    '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000}
  };

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opd1   = '0;
    bus.in_opd2   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_res", bus.out_res, 32'd0);
    chk("rst_out_flags", {29'd0, bus.out_flags}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_mul_opd1", bus.mul_opd1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: push edge, ISSUE edge, then out_valid.
    bus.in_valid = 1'b1;
    bus.in_opd1  = 32'h3FC00000;
    bus.in_opd2  = 32'h40000000;
    @(negedge clk);
    chk("lat_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q.push_back({32'h40400000, 3'b000});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("lat_cycle0", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle1", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", {31'd0, bus.out_valid}, 32'd1);
    wait_drain();

    foreach (vecs[i]) push_pair(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);
    wait_drain();

    // Back-pressure: three accepts fill operand register plus FIFO.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pair(bp[i].a, bp[i].b, bp[i].res, bp[i].flags);
    bus.in_valid = 1'b1;
    bus.in_opd1  = bp[3].a;
    bus.in_opd2  = bp[3].b;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_valid_high", {31'd0, bus.out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push_pair(bp[3].a, bp[3].b, bp[3].res, bp[3].flags);
    wait_drain();

    // Reset while holding a result with two pairs queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pair(bp[i].a, bp[i].b, bp[i].res, bp[i].flags);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_output", {31'd0, bus.out_valid}, 32'd0);
    push_pair(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
